// File: rtl/fp_mul_stream.sv
// Streaming IEEE-754 single-precision multiplier: pairs A/B beats into a fixed 4-stage
// round-to-nearest-even pipeline that stalls globally under downstream back-pressure.
module fp_mul_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_areset,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    input  logic                    s00_axis_tvalid,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic [CNT_WIDTH-1:0]    prod_count
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("fp_mul_stream supports DATA_WIDTH == 32 only");
    end

    logic        stall, in_fire, out_fire;
    logic        phase_q;
    logic [31:0] a_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // S1: sign, biased exponent sum, raw mantissa product, operand classes
    logic        s1_valid_d, s1_last_d, s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
    logic        s1_valid_q, s1_last_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [9:0]  s1_exp_d, s1_exp_q;
    logic [47:0] s1_prod_d, s1_prod_q;
    // S2: normalised mantissa with guard and sticky
    logic        s2_g_d, s2_st_d, s2_exp_inc;
    logic        s2_valid_q, s2_last_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q, s2_g_q, s2_st_q;
    logic [9:0]  s2_exp_d, s2_exp_q;
    logic [22:0] s2_man_d, s2_man_q;
    // S3: rounded mantissa
    logic        s3_valid_q, s3_last_q, s3_sign_q, s3_nan_q, s3_inf_q, s3_zero_q;
    logic        s3_rnd, s3_carry;
    logic [9:0]  s3_exp_d, s3_exp_q;
    logic [22:0] s3_man_d, s3_man_q;
    // S4: output register
    logic        s4_valid_q, s4_last_q;
    logic [31:0] s4_data_d, s4_data_q;

    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        e_ovf, e_flush;

    assign stall           = s4_valid_q & ~m00_axis_tready;
    assign s00_axis_tready = ~stall;
    assign in_fire         = s00_axis_tvalid & s00_axis_tready;
    assign out_fire        = s4_valid_q & m00_axis_tready;

    always_comb begin
        a_exp  = a_q[30:23];
        a_frac = a_q[22:0];
        b_exp  = s00_axis_tdata[30:23];
        b_frac = s00_axis_tdata[22:0];
        // Denormals have a zero exponent and are treated as zero.
        a_zero = (a_exp == 8'h00);
        b_zero = (b_exp == 8'h00);
        a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
        b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
        a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
        b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

        s1_valid_d = in_fire & phase_q;
        s1_last_d  = s00_axis_tlast;
        s1_sign_d  = a_q[31] ^ s00_axis_tdata[31];
        s1_nan_d   = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf_d   = a_inf | b_inf;
        s1_zero_d  = a_zero | b_zero;
        s1_exp_d   = {2'b00, a_exp} + {2'b00, b_exp} - 10'd127;
        s1_prod_d  = {24'd0, 1'b1, a_frac} * {24'd0, 1'b1, b_frac};
    end

    always_comb begin
        s2_man_d   = s1_prod_q[45:23];
        s2_g_d     = s1_prod_q[22];
        s2_st_d    = |s1_prod_q[21:0];
        s2_exp_inc = 1'b0;
        if (s1_prod_q[47]) begin
            s2_man_d   = s1_prod_q[46:24];
            s2_g_d     = s1_prod_q[23];
            s2_st_d    = |s1_prod_q[22:0];
            s2_exp_inc = 1'b1;
        end
        s2_exp_d = s1_exp_q + {9'd0, s2_exp_inc};
    end

    always_comb begin
        s3_rnd                 = s2_g_q & (s2_st_q | s2_man_q[0]);
        {s3_carry, s3_man_d}   = {1'b0, s2_man_q} + {23'd0, s3_rnd};
        s3_exp_d               = s2_exp_q + {9'd0, s3_carry};
    end

    // Exponent is a 10-bit two's-complement value; bit 9 marks negative.
    always_comb begin
        e_ovf   = ~s3_exp_q[9] && (s3_exp_q >= 10'd255);
        e_flush = s3_exp_q[9] || (s3_exp_q == 10'd0);
        if (s3_nan_q)       s4_data_d = 32'h7FC00000;
        else if (s3_inf_q)  s4_data_d = {s3_sign_q, 8'hFF, 23'd0};
        else if (s3_zero_q) s4_data_d = {s3_sign_q, 31'd0};
        else if (e_ovf)     s4_data_d = {s3_sign_q, 8'hFF, 23'd0};
        else if (e_flush)   s4_data_d = {s3_sign_q, 31'd0};
        else                s4_data_d = {s3_sign_q, s3_exp_q[7:0], s3_man_q};
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            phase_q    <= 1'b0;
            a_q        <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
            s4_last_q  <= 1'b0;
            s4_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            if (out_fire) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (!stall) begin
                if (in_fire) begin
                    phase_q <= ~phase_q;
                    if (!phase_q) a_q <= s00_axis_tdata;
                end
                s1_valid_q <= s1_valid_d;
                s1_last_q  <= s1_last_d;
                s1_sign_q  <= s1_sign_d;
                s1_nan_q   <= s1_nan_d;
                s1_inf_q   <= s1_inf_d;
                s1_zero_q  <= s1_zero_d;
                s1_exp_q   <= s1_exp_d;
                s1_prod_q  <= s1_prod_d;

                s2_valid_q <= s1_valid_q;
                s2_last_q  <= s1_last_q;
                s2_sign_q  <= s1_sign_q;
                s2_nan_q   <= s1_nan_q;
                s2_inf_q   <= s1_inf_q;
                s2_zero_q  <= s1_zero_q;
                s2_exp_q   <= s2_exp_d;
                s2_man_q   <= s2_man_d;
                s2_g_q     <= s2_g_d;
                s2_st_q    <= s2_st_d;

                s3_valid_q <= s2_valid_q;
                s3_last_q  <= s2_last_q;
                s3_sign_q  <= s2_sign_q;
                s3_nan_q   <= s2_nan_q;
                s3_inf_q   <= s2_inf_q;
                s3_zero_q  <= s2_zero_q;
                s3_exp_q   <= s3_exp_d;
                s3_man_q   <= s3_man_d;

                s4_valid_q <= s3_valid_q;
                s4_last_q  <= s3_last_q;
                s4_data_q  <= s4_data_d;
            end
        end
    end

    assign m00_axis_tvalid = s4_valid_q;
    assign m00_axis_tdata  = s4_data_q;
    assign m00_axis_tlast  = s4_last_q & s4_valid_q;
    assign m00_axis_tstrb  = '1;
    assign prod_count      = cnt_q;

endmodule

// File: tb/tb_fp_mul_stream.sv
// Directed bench for fp_mul_stream: hand-computed products checked in order by a
// negedge monitor, plus latency, back-pressure stability and mid-stream reset.
module tb_fp_mul_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] prod_count;

    int n_total = 0;
    int n_bad = 0;
    int exp_count = 0;
    logic [32:0] exp_q[$];
    logic rand_rdy = 1'b0;

    logic [31:0] bp_a[10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                              32'hBF800000, 32'h40800000, 32'h3FC00000, 32'h41200000,
                              32'hC0000000, 32'h7F800000};
    logic [31:0] bp_b[10] = '{32'h3F800000, 32'h40400000, 32'h40400000, 32'h3F000000,
                              32'h40A00000, 32'h40800000, 32'h3FC00000, 32'h41200000,
                              32'hC0000000, 32'hBF800000};
    logic [31:0] bp_p[10] = '{32'h3F800000, 32'h40C00000, 32'h41100000, 32'h3E800000,
                              32'hC0A00000, 32'h41800000, 32'h40100000, 32'h42C80000,
                              32'h40800000, 32'hFF800000};

    fp_mul_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tvalid (s_tvalid),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .prod_count      (prod_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // One beat, held until the DUT accepts it on a rising edge.
    task automatic send(input logic [31:0] d, input logic last);
        int budget = 200;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        forever begin
            #2;
            if (s_tready) begin
                @(posedge clk);
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 32'd1, 32'd0);
                @(posedge clk);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic a_last, input logic [31:0] b,
                             input logic b_last, input logic [31:0] prod);
        exp_q.push_back({b_last, prod});
        exp_count++;
        send(a, a_last);
        send(b, b_last);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall = 1'b0;
    logic [32:0] e_item;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_item = exp_q.pop_front();
                    chk("data", m_tdata, e_item[31:0]);
                    chk("last", 32'(m_tlast), 32'(e_item[32]));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_count", 32'(prod_count), 32'd0);
        chk("tstrb", 32'(m_tstrb), 32'hF);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic product and pipeline latency
        send_pair(32'h3FC00000, 1'b0, 32'h40000000, 1'b0, 32'h40400000);
        k = 0;
        while (!m_tvalid && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'd4);
        wait_drain(50);
        chk("count_basic", 32'(prod_count), 32'd1);

        send_pair(32'hC0000000, 1'b0, 32'h40400000, 1'b0, 32'hC0C00000);
        send_pair(32'h3F800001, 1'b0, 32'h3FC00000, 1'b0, 32'h3FC00002);
        send_pair(32'h3F800001, 1'b0, 32'h3F800001, 1'b0, 32'h3F800002);
        send_pair(32'h7F000000, 1'b0, 32'h40000000, 1'b0, 32'h7F800000);
        send_pair(32'h00800000, 1'b0, 32'h3F000000, 1'b0, 32'h00000000);
        send_pair(32'h7F800000, 1'b0, 32'h00000000, 1'b0, 32'h7FC00000);
        send_pair(32'h7FC00000, 1'b0, 32'h3F800000, 1'b0, 32'h7FC00000);
        send_pair(32'h80000000, 1'b1, 32'h40000000, 1'b0, 32'h80000000);
        send_pair(32'h00400000, 1'b0, 32'h7F000000, 1'b1, 32'h00000000);
        wait_drain(50);
        chk("count_directed", 32'(prod_count), 32'(exp_count));

        // Random downstream back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_pair(bp_a[i], 1'b0, bp_b[i], (i == 9), bp_p[i]);
        end
        wait_drain(500);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        @(negedge clk);
        chk("count_bp", 32'(prod_count), 32'(exp_count));

        // Mid-stream reset with products held in a stalled pipeline
        m_tready = 1'b0;
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40400000, 1'b1);
        send(32'h41000000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_count", 32'(prod_count), 32'd0);
        chk("mid_rst_tready", 32'(s_tready), 32'd1);
        m_tready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_idle", 32'(m_tvalid), 32'd0);
        send_pair(32'h40A00000, 1'b0, 32'h40000000, 1'b1, 32'h41200000);
        wait_drain(50);
        chk("count_after_rst", 32'(prod_count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
